// File: rtl/acq_trigger_sequencer.sv
// Acquisition trigger sequencer: arms on START, optionally gates, counts start
// events, acquires until enough stop events, memory full, timeout or abort.
module acq_trigger_sequencer #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 16,
  parameter int TMO_W   = 24
) (
  input  logic               CLK_MASTER,
  input  logic               RESET_N,
  input  logic               START,
  input  logic               ABORT,
  input  logic               CKE_TICK,
  input  logic [NUM_EVT-1:0] EVT_IN,
  input  logic [NUM_EVT-1:0] START_MASK,
  input  logic [NUM_EVT-1:0] STOP_MASK,
  input  logic [CNT_W-1:0]   START_NUM,
  input  logic [CNT_W-1:0]   STOP_NUM,
  input  logic               PRE_GATE_EN,
  input  logic               PRE_GATE_EVT,
  input  logic               POST_GATE_EN,
  input  logic               POST_GATE_EVT,
  input  logic [TMO_W-1:0]   TIMEOUT_VAL,
  input  logic               MEM_FULL,
  output logic               WAITING,
  output logic               ACQUIRING,
  output logic               DONE,
  output logic [1:0]         STOP_REASON,
  output logic [2:0]         STATE
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREGATE  = 3'd1,
    ST_WAIT     = 3'd2,
    ST_POSTGATE = 3'd3,
    ST_ACQ      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RSN_STOP    = 2'b00,
    RSN_MEMFULL = 2'b01,
    RSN_TIMEOUT = 2'b10,
    RSN_ABORT   = 2'b11
  } reason_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_scnt;
  logic [CNT_W-1:0]   r_ecnt;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_done;
  reason_t            r_reason;
  logic [NUM_EVT-1:0] r_evt_q;
  logic [NUM_EVT-1:0] r_evt_q2;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_scnt_nxt;
  logic [CNT_W-1:0]   w_ecnt_nxt;
  logic [TMO_W-1:0]   w_tmo_nxt;
  logic               w_done_nxt;
  reason_t            w_reason_nxt;

  logic [NUM_EVT-1:0] w_evt_edge;
  logic               w_start_match;
  logic               w_stop_match;
  logic               w_wait_phase;
  logic               w_active;
  logic               w_timeout;

  assign w_evt_edge    = r_evt_q & ~r_evt_q2;
  // An empty mask means "any cycle qualifies", not "never".
  assign w_start_match = (START_MASK == '0) || (|(w_evt_edge & START_MASK));
  assign w_stop_match  = (STOP_MASK == '0)  || (|(w_evt_edge & STOP_MASK));

  assign w_wait_phase = (r_state == ST_PREGATE) || (r_state == ST_WAIT) ||
                        (r_state == ST_POSTGATE);
  assign w_active     = w_wait_phase || (r_state == ST_ACQ);
  assign w_timeout    = (TIMEOUT_VAL != '0) && (r_tmo >= TIMEOUT_VAL);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_state_nxt  = r_state;
    w_scnt_nxt   = r_scnt;
    w_ecnt_nxt   = r_ecnt;
    w_tmo_nxt    = r_tmo;
    w_done_nxt   = 1'b0;
    w_reason_nxt = r_reason;

    if (w_wait_phase && CKE_TICK && (r_tmo != '1))
      w_tmo_nxt = r_tmo + TMO_W'(1);

    if (w_active && ABORT) begin
      w_state_nxt  = ST_IDLE;
      w_done_nxt   = 1'b1;
      w_reason_nxt = RSN_ABORT;
    end else if (w_wait_phase && w_timeout) begin
      w_state_nxt  = ST_IDLE;
      w_done_nxt   = 1'b1;
      w_reason_nxt = RSN_TIMEOUT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START && !ABORT) begin
            w_scnt_nxt   = START_NUM;
            w_ecnt_nxt   = STOP_NUM;
            w_tmo_nxt    = '0;
            w_reason_nxt = RSN_STOP;
            w_state_nxt  = PRE_GATE_EN ? ST_PREGATE : ST_WAIT;
          end
        end
        ST_PREGATE: begin
          if (PRE_GATE_EVT) w_state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (w_start_match) begin
            if (r_scnt != '0) w_scnt_nxt  = r_scnt - CNT_W'(1);
            else              w_state_nxt = POST_GATE_EN ? ST_POSTGATE : ST_ACQ;
          end
        end
        ST_POSTGATE: begin
          if (POST_GATE_EVT) w_state_nxt = ST_ACQ;
        end
        ST_ACQ: begin
          if (MEM_FULL) begin
            w_state_nxt  = ST_IDLE;
            w_done_nxt   = 1'b1;
            w_reason_nxt = RSN_MEMFULL;
          end else if (w_stop_match) begin
            if (r_ecnt != '0) begin
              w_ecnt_nxt = r_ecnt - CNT_W'(1);
            end else begin
              w_state_nxt  = ST_IDLE;
              w_done_nxt   = 1'b1;
              w_reason_nxt = RSN_STOP;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= ST_IDLE;
      r_scnt   <= '0;
      r_ecnt   <= '0;
      r_tmo    <= '0;
      r_done   <= 1'b0;
      r_reason <= RSN_STOP;
      r_evt_q  <= '0;
      r_evt_q2 <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state  <= w_state_nxt;
      r_scnt   <= w_scnt_nxt;
      r_ecnt   <= w_ecnt_nxt;
      r_tmo    <= w_tmo_nxt;
      r_done   <= w_done_nxt;
      r_reason <= w_reason_nxt;
      r_evt_q  <= EVT_IN;
      r_evt_q2 <= r_evt_q;
    end
  end

  assign STATE       = r_state;
  assign WAITING     = (r_state == ST_PREGATE) || (r_state == ST_WAIT);
  assign ACQUIRING   = (r_state == ST_POSTGATE) || (r_state == ST_ACQ);
  assign DONE        = r_done;
  assign STOP_REASON = r_reason;

endmodule
